da_tlc5620_rx: RTL and testbench

DA_TLC5620_RX -- requirements
Module: da_tlc5620_rx

---
 rtl/da_tlc5620_if.sv | 22 ++
 rtl/da_tlc5620_rx.sv | 100 ++++++++++
 tb/tb_da_tlc5620_rx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/da_tlc5620_if.sv
// Serial bus of a TLC5620-style quad DAC as seen by the receiver.
// Signals: da_io_clk (bit clock), da_data (MSB first), da_load (word strobe, low), da_ldac (update strobe, low).
interface da_tlc5620_if;
  logic da_io_clk;
  logic da_data;
  logic da_load;
  logic da_ldac;

  modport master (
    output da_io_clk,
    output da_data,
    output da_load,
    output da_ldac
  );

  modport slave (
    input da_io_clk,
    input da_data,
    input da_load,
    input da_ldac
  );
endinterface

// File: rtl/da_tlc5620_rx.sv
// Receiver emulating a TLC5620 quad 8-bit DAC register file from its serial bus.
// Ports: sys_clk/sys_rst, da (serial bus slave), dac_a..dac_d, rng_out, word_valid, frame_err.
module da_tlc5620_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  da_tlc5620_if.slave da,
  output logic [7:0] dac_a,
  output logic [7:0] dac_b,
  output logic [7:0] dac_c,
  output logic [7:0] dac_d,
  output logic [3:0] rng_out,
  output logic       word_valid,
  output logic       frame_err
);

  // bit0 io_clk, bit1 data, bit2 load, bit3 ldac
  localparam logic [3:0] IDLE = 4'b1100;

  logic [3:0] raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] hist_q;
  logic [3:0] syn;
  logic [3:0] fall;

  logic [10:0] sr_q;
  logic [3:0]  cnt_q;
  logic [8:0]  lat_q [4];
  logic [8:0]  lat_d [4];
  logic [8:0]  out_q [4];
  logic        accept;
  logic        reject;
  logic        shift;
  logic        upd;

  assign raw  = {da.da_ldac, da.da_load, da.da_data, da.da_io_clk};
  assign syn  = sync_q[SYNC_STAGES-1];
  assign fall = ~syn & hist_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= IDLE;
      hist_q <= IDLE;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist_q <= syn;
    end
  end

  // Bits are only taken while the word strobe is inactive.
  assign shift  = fall[0] & syn[2];
  assign accept = fall[2] & (cnt_q == 4'd11);
  assign reject = fall[2] & (cnt_q != 4'd11);
  // A held-low ldac makes an accepted word transparent to the outputs.
  assign upd    = (accept & ~syn[3]) | fall[3];

  always_comb begin
    lat_d = lat_q;
    if (accept)
      lat_d[sr_q[10:9]] = sr_q[8:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lat_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      word_valid <= accept;
      frame_err  <= reject;
      if (fall[2]) begin
        cnt_q <= '0;
      end else if (shift) begin
        sr_q <= {sr_q[9:0], syn[1]};
        if (cnt_q != 4'd15)
          cnt_q <= cnt_q + 4'd1;
      end
      lat_q <= lat_d;
      if (upd)
        out_q <= lat_d;
    end
  end

  assign dac_a   = out_q[0][7:0];
  assign dac_b   = out_q[1][7:0];
  assign dac_c   = out_q[2][7:0];
  assign dac_d   = out_q[3][7:0];
  assign rng_out = {out_q[3][8], out_q[2][8],
                    out_q[1][8], out_q[0][8]};

endmodule

// File: tb/tb_da_tlc5620_rx.sv
// Scoreboard bench for da_tlc5620_rx driving directed serial words.
// Expected pulses are queued by the stimulus and checked by a monitor.
module tb_da_tlc5620_rx;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] dac_a;
  logic [7:0] dac_b;
  logic [7:0] dac_c;
  logic [7:0] dac_d;
  logic [3:0] rng_out;
  logic       word_valid;
  logic       frame_err;

  da_tlc5620_if bus ();

  da_tlc5620_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .da         (bus.slave),
    .dac_a      (dac_a),
    .dac_b      (dac_b),
    .dac_c      (dac_c),
    .dac_d      (dac_d),
    .rng_out    (rng_out),
    .word_valid (word_valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit         err;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [3:0] rng;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_miss = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic void push(input bit err,
                               input logic [7:0] a,
                               input logic [7:0] b,
                               input logic [7:0] c,
                               input logic [7:0] d,
                               input logic [3:0] r);
    exp_t x;
    x.err = err;
    x.a   = a;
    x.b   = b;
    x.c   = c;
    x.d   = d;
    x.rng = r;
    q.push_back(x);
  endfunction

  always @(negedge sys_clk) begin
    if (word_valid || frame_err) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pulse: got wv=%b fe=%b want none",
                 word_valid, frame_err);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {62'd0, word_valid, frame_err},
              e.err ? 64'd1 : 64'd2);
        check("pulse_outs", {28'd0, dac_a, dac_b, dac_c, dac_d, rng_out},
              {28'd0, e.a, e.b, e.c, e.d, e.rng});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge sys_clk);
      bus.da_data   = v[i];
      bus.da_io_clk = 1'b1;
      wait_n(4);
      bus.da_io_clk = 1'b0;
      wait_n(4);
    end
  endtask

  task automatic pulse_load(input int toggles);
    @(negedge sys_clk);
    bus.da_load = 1'b0;
    wait_n(6);
    for (int i = 0; i < toggles; i++) begin
      bus.da_io_clk = 1'b1;
      wait_n(4);
      bus.da_io_clk = 1'b0;
      wait_n(4);
    end
    bus.da_load = 1'b1;
    wait_n(6);
  endtask

  task automatic pulse_ldac();
    @(negedge sys_clk);
    bus.da_ldac = 1'b0;
    wait_n(6);
    bus.da_ldac = 1'b1;
    wait_n(6);
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.da_io_clk = 1'b0;
    bus.da_data   = 1'b0;
    bus.da_load   = 1'b1;
    bus.da_ldac   = 1'b1;
    wait_n(4);
    check("reset_outs",
          {26'd0, dac_a, dac_b, dac_c, dac_d, rng_out, word_valid, frame_err},
          64'd0);
    sys_rst = 1'b0;
    wait_n(4);

    // word to A, ldac high: latch only, then ldac pulse
    push(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    send_bits(16'b00_0_10100101, 11);
    pulse_load(0);
    check("a_before_ldac", {56'd0, dac_a}, 64'h00);
    pulse_ldac();
    check("a_after_ldac", {56'd0, dac_a}, 64'hA5);
    check("rng_after_ldac", {60'd0, rng_out}, 64'h0);

    // word to D with ldac held low, 3-edge latency
    @(negedge sys_clk);
    bus.da_ldac = 1'b0;
    wait_n(6);
    push(0, 8'hA5, 8'h00, 8'h00, 8'hFF, 4'b1000);
    send_bits(16'b11_1_11111111, 11);
    @(negedge sys_clk);
    bus.da_load = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check("d_edge2", {56'd0, dac_d}, 64'h00);
    @(posedge sys_clk);
    #1;
    check("d_edge3", {56'd0, dac_d}, 64'hFF);
    check("rng3_edge3", {63'd0, rng_out[3]}, 64'd1);
    wait_n(5);
    bus.da_load = 1'b1;
    wait_n(6);
    bus.da_ldac = 1'b1;
    wait_n(6);
    check("abc_kept", {40'd0, dac_a, dac_b, dac_c}, {40'd0, 24'hA50000});

    // short and long frames are rejected
    push(1, 8'hA5, 8'h00, 8'h00, 8'hFF, 4'b1000);
    push(1, 8'hA5, 8'h00, 8'h00, 8'hFF, 4'b1000);
    send_bits(16'h0155, 10);
    pulse_load(0);
    send_bits(16'h0ABC, 12);
    pulse_load(0);
    pulse_ldac();
    check("bad_frames_outs", {28'd0, dac_a, dac_b, dac_c, dac_d, rng_out},
          {28'd0, 8'hA5, 8'h00, 8'h00, 8'hFF, 4'b1000});

    // load and ldac fall together
    push(0, 8'hA5, 8'h3C, 8'h00, 8'hFF, 4'b1000);
    send_bits(16'b01_0_00111100, 11);
    @(negedge sys_clk);
    bus.da_load = 1'b0;
    bus.da_ldac = 1'b0;
    wait_n(6);
    bus.da_load = 1'b1;
    bus.da_ldac = 1'b1;
    wait_n(6);
    check("b_same_cycle", {56'd0, dac_b}, 64'h3C);

    // reset mid-frame
    send_bits(16'b100010, 6);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    wait_n(3);
    sys_rst = 1'b0;
    wait_n(4);
    check("midframe_rst_outs", {28'd0, dac_a, dac_b, dac_c, dac_d, rng_out},
          64'd0);
    push(0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    send_bits(16'b10_0_01010101, 11);
    pulse_load(3);
    pulse_ldac();
    check("c_after_rst", {28'd0, dac_a, dac_b, dac_c, dac_d, rng_out},
          {28'd0, 8'h00, 8'h00, 8'h55, 8'h00, 4'b0000});

    // io_clk toggles during load low were ignored; next word is clean
    push(0, 8'h00, 8'h00, 8'h55, 8'h00, 4'b0000);
    send_bits(16'b00_1_00001111, 11);
    pulse_load(0);
    pulse_ldac();
    check("a_after_toggles", {28'd0, dac_a, dac_b, dac_c, dac_d, rng_out},
          {28'd0, 8'h0F, 8'h00, 8'h55, 8'h00, 4'b0001});

    wait_n(10);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
